// File: rtl/control_unit.sv
// Multicycle RV64 control FSM: steps each instruction through fetch, decode,
// execute, memory and writeback, decoding every datapath flag from state + IR.
module control_unit #(
  parameter logic [3:0] ALU_ADD = 4'd1,
  parameter logic [3:0] ALU_SUB = 4'd2,
  parameter logic [3:0] ALU_AND = 4'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic        PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic [1:0]  MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        illegal,
  output logic [4:0]  state_out
);

  // state    | meaning
  // FETCH    | present PC to instruction memory
  // IR_LOAD  | capture IR
  // DECODE   | read rs1/rs2, ALUOut=PC+imm, dispatch on opcode
  // *_EXEC   | ALU op into ALUOut (R, I, LUI)
  // ALU_WB   | write ALUOut to rd, PC+4
  // MEM_ADDR | effective address into ALUOut
  // LD_WAIT  | data memory read latency
  // LD_MDR   | capture MDR
  // LD_WB    | spliced MDR to rd, PC+4
  // ST_MEM   | data memory write, PC+4
  // BRANCH   | compare rs1/rs2, conditional PC<=target
  // PC_INC   | not-taken branch PC+4
  // JAL      | PC<=target, ALUOut=old PC+4
  // JAL_WB   | link register write
  // TRAP     | unsupported encoding, held until reset
  typedef enum logic [4:0] {
    FETCH, IR_LOAD, DECODE, R_EXEC, I_EXEC, LUI_EXEC, ALU_WB, MEM_ADDR,
    LD_WAIT, LD_MDR, LD_WB, ST_MEM, BRANCH, PC_INC, JAL, JAL_WB, TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_ok, i_ok, ld_ok, st_ok, br_ok;
  logic       taken;
  logic       pc_plus4;
  logic       unused_bits;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign unused_bits = ^{alu_zero, alu_greater, instruction[24:15], instruction[11:7]};

  assign r_ok  = ((funct3 == 3'b000) && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                 ((funct3 == 3'b111) && (funct7 == 7'b0000000));
  assign i_ok  = (funct3 == 3'b000);
  assign ld_ok = funct3 inside {3'b011, 3'b010, 3'b001, 3'b100};
  assign st_ok = funct3 inside {3'b011, 3'b010, 3'b001, 3'b000};
  assign br_ok = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_equal;
      3'b001:  taken = !alu_equal;
      3'b100:  taken = alu_less;
      3'b101:  taken = !alu_less;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pc_plus4    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUOp       = 4'd0;
    LoadAOut    = 1'b0;
    RegWrite    = 1'b0;
    LoadRegA    = 1'b0;
    LoadRegB    = 1'b0;
    MemToReg    = 2'd0;
    DMemOp      = 1'b0;
    LoadMDR     = 1'b0;
    LoadSplice  = 2'd0;
    StoreSplice = 2'd0;
    IMemRead    = 1'b0;
    IRWrite     = 1'b0;
    illegal     = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          IMemRead   = 1'b1;
          next_state = IR_LOAD;
        end
        IR_LOAD: begin
          IMemRead   = 1'b1;
          IRWrite    = 1'b1;
          next_state = DECODE;
        end
        DECODE: begin
          LoadRegA = 1'b1;
          LoadRegB = 1'b1;
          ALUSrcB  = 2'd2;
          ALUOp    = ALU_ADD;
          LoadAOut = 1'b1;
          case (opcode)
            OP_R:      next_state = r_ok  ? R_EXEC   : TRAP;
            OP_I:      next_state = i_ok  ? I_EXEC   : TRAP;
            OP_LUI:    next_state = LUI_EXEC;
            OP_LOAD:   next_state = ld_ok ? MEM_ADDR : TRAP;
            OP_STORE:  next_state = st_ok ? MEM_ADDR : TRAP;
            OP_BRANCH: next_state = br_ok ? BRANCH   : TRAP;
            OP_JAL:    next_state = JAL;
            default:   next_state = TRAP;
          endcase
        end
        R_EXEC: begin
          ALUSrcA  = 2'd1;
          LoadAOut = 1'b1;
          if (funct7 == 7'b0100000)  ALUOp = ALU_SUB;
          else if (funct3 == 3'b111) ALUOp = ALU_AND;
          else                       ALUOp = ALU_ADD;
          next_state = ALU_WB;
        end
        I_EXEC, LUI_EXEC, MEM_ADDR: begin
          ALUSrcA  = (state == LUI_EXEC) ? 2'd2 : 2'd1;
          ALUSrcB  = 2'd2;
          ALUOp    = ALU_ADD;
          LoadAOut = 1'b1;
          if (state != MEM_ADDR)   next_state = ALU_WB;
          else if (opcode[5])      next_state = ST_MEM;
          else                     next_state = LD_WAIT;
        end
        ALU_WB: begin
          RegWrite   = 1'b1;
          pc_plus4   = 1'b1;
          next_state = FETCH;
        end
        LD_WAIT: next_state = LD_MDR;
        LD_MDR: begin
          LoadMDR    = 1'b1;
          next_state = LD_WB;
        end
        // ld/lw/lh/lbu and sd/sw/sh/sb both map to the inverted low funct3 bits
        LD_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = 2'd1;
          LoadSplice = ~funct3[1:0];
          pc_plus4   = 1'b1;
          next_state = FETCH;
        end
        ST_MEM: begin
          DMemOp      = 1'b1;
          StoreSplice = ~funct3[1:0];
          pc_plus4    = 1'b1;
          next_state  = FETCH;
        end
        BRANCH: begin
          ALUSrcA     = 2'd1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 1'b1;
          next_state  = taken ? FETCH : PC_INC;
        end
        PC_INC: begin
          pc_plus4   = 1'b1;
          next_state = FETCH;
        end
        JAL: begin
          PCWrite    = 1'b1;
          PCSource   = 1'b1;
          ALUSrcB    = 2'd1;
          ALUOp      = ALU_ADD;
          LoadAOut   = 1'b1;
          next_state = JAL_WB;
        end
        JAL_WB: begin
          RegWrite   = 1'b1;
          next_state = FETCH;
        end
        TRAP:    illegal = 1'b1;
        default: next_state = TRAP;
      endcase
      if (pc_plus4) begin
        ALUSrcA  = 2'd0;
        ALUSrcB  = 2'd1;
        ALUOp    = ALU_ADD;
        PCWrite  = 1'b1;
        PCSource = 1'b0;
      end
    end
  end

  assign PCWriteState = PCWrite | (PCWriteCond & taken);
  assign state_out    = reset ? state : 5'd0;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle RV64 control FSM that drives every control flag of the processing datapath.
- Consumes the datapath's instruction register (instruction) and ALU comparison flags (alu_zero/equal/greater/less).
- Sequences fetch, decode, execute, memory and writeback per instruction.
- Supported: add, sub, and, addi, lui, ld/lw/lh/lbu, sd/sw/sh/sb, beq/bne/blt/bge, jal. Any other encoding parks the FSM in TRAP.

Parameters:
ALU_ADD, 4'd1, ALUOp code for a+b
ALU_SUB, 4'd2, ALUOp code for a-b; comparison flags are valid in this mode
ALU_AND, 4'd3, ALUOp code for a&b

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
instruction  in  32  IR contents (instruction_out of the datapath)
alu_zero, alu_equal, alu_greater, alu_less  in  1 each  combinational ALU flags
PCWrite, PCWriteCond, PCWriteState, PCSource  out  1 each  PC control
ALUSrcA, ALUSrcB  out  2 each  A: 0=PC, 1=regA, 2=zero; B: 0=regB, 1=4, 2=imm, 3=imm<<2
ALUOp  out  4  ALU function
LoadAOut, RegWrite, LoadRegA, LoadRegB  out  1 each  register loads
MemToReg  out  2  0=ALUOut, 1=spliced MDR, 2=PC
DMemOp, LoadMDR  out  1 each  data memory write; MDR load
LoadSplice  out  2  0=ld, 1=lw, 2=lh, 3=lbu
StoreSplice  out  2  0=sd, 1=sw, 2=sh, 3=sb
IMemRead, IRWrite  out  1 each  instruction fetch; IR load
illegal  out  1  high while in TRAP
state_out  out  5  current state encoding, for debug

Behaviour:
- reset==0 at a clk edge: state<=FETCH. While reset==0, every output is forced to 0, including state_out and illegal.
- Outputs are decoded combinationally from state plus instruction fields. Every output not listed for a state is 0.
- PCWriteState = PCWrite | (PCWriteCond & taken).
  - taken: beq=alu_equal, bne=!alu_equal, blt=alu_less, bge=!alu_less.
- Memories are synchronous-read: data is valid one cycle after the address is presented.
- "PC+4" means ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCWrite=1, PCSource=0.
- FETCH: IMemRead=1 -> IR_LOAD.
- IR_LOAD: IMemRead=1, IRWrite=1 -> DECODE.
- DECODE: LoadRegA=1, LoadRegB=1; ALUSrcA=0, ALUSrcB=2, ADD, LoadAOut=1 (ALUOut=PC+imm, the branch/jal target).
  - Dispatch on opcode[6:0]: 0110011->R_EXEC, 0010011->I_EXEC, 0110111->LUI_EXEC, 0000011 or 0100011->MEM_ADDR, 1100011->BRANCH, 1101111->JAL, else->TRAP.
  - Unsupported funct3/funct7 within a known opcode -> TRAP.
- R_EXEC: ALUSrcA=1, ALUSrcB=0, LoadAOut=1. ALUOp is ADD, SUB (funct7=0100000) or AND (funct3=111). -> ALU_WB.
- I_EXEC: ALUSrcA=1, ALUSrcB=2, ADD, LoadAOut=1 -> ALU_WB.
- LUI_EXEC: ALUSrcA=2, ALUSrcB=2, ADD, LoadAOut=1 -> ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, PC+4 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD, LoadAOut=1 -> LD_WAIT (load) or ST_MEM (store).
- LD_WAIT -> LD_MDR.
- LD_MDR: LoadMDR=1 -> LD_WB.
- LD_WB: RegWrite=1, MemToReg=1, LoadSplice from funct3 (011->0, 010->1, 001->2, 100->3), PC+4 -> FETCH.
- ST_MEM: DMemOp=1, StoreSplice from funct3 (011->0, 010->1, 001->2, 000->3), PC+4 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond=1, PCSource=1. Taken -> FETCH; not taken -> PC_INC.
- PC_INC: PC+4 -> FETCH.
- JAL: PCWrite=1, PCSource=1 (PC<=target). In the same cycle, ALUSrcA=0, ALUSrcB=1, ADD, LoadAOut=1, so ALUOut=old PC+4. -> JAL_WB.
- JAL_WB: RegWrite=1, MemToReg=0 -> FETCH.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.
- Reset mid-instruction: a pending RegWrite or DMemOp is never issued. The next instruction starts at FETCH.
- Cycle counts: ALU ops 5, load 7, store 5, branch taken 4 / not taken 5, jal 5.

Test Plan:
- add x3,x1,x2 (0x002081B3): state sequence FETCH,IR_LOAD,DECODE,R_EXEC,ALU_WB. R_EXEC shows ALUOp=1, ALUSrcA=1, ALUSrcB=0. ALU_WB shows RegWrite=1, PCWriteState=1.
- lw x5,8(x1) (0x0080A283): 7 cycles. LD_MDR shows LoadMDR=1. LD_WB shows LoadSplice=1, MemToReg=1, RegWrite=1.
- beq with alu_equal=1: BRANCH shows PCWriteState=1, PCSource=1, then FETCH.
- beq with alu_equal=0: PCWriteState=0 in BRANCH, then PC_INC with PCWrite=1, PCSource=0. Repeat the pair for bne, blt and bge.
- sb (funct3=000): ST_MEM shows DMemOp=1, StoreSplice=3. jal: JAL shows PCWrite=1, PCSource=1, LoadAOut=1; JAL_WB shows RegWrite=1.
- Opcode 0x7F: TRAP with illegal=1, held for 10 cycles. Separately, reset=0 pulsed during LD_WAIT: all outputs 0 while reset is low, no RegWrite is ever issued, and the FSM resumes at FETCH.
